// File: rtl/apb_completer_mem_if.sv
// APB bus bundle between a requester and the register-array completer.
// Requester drives the request fields; completer drives the response.
interface apb_completer_mem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_completer_mem.sv
// APB completer backed by a DEPTH x DATA_W register array, registered outputs.
// Optional wait states enabled by defining APB_WAIT_STATES_EN.
module apb_completer_mem #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    apb_completer_mem_if.slave apb
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef APB_WAIT_STATES_EN
    localparam int WAIT_N = WAIT_CYCLES;
`else
    localparam int WAIT_N = 0;
`endif
    localparam logic [CNT_W-1:0]  WAIT_LD = CNT_W'(WAIT_N);
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              we;
    logic              new_err;
    logic [IDX_W-1:0]  new_idx;

    assign new_err = ({1'b0, apb.paddr} >= DEPTH_V);
    assign new_idx = apb.paddr[IDX_W-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        we        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // penable without a prior setup phase is ignored
                if (apb.psel && !apb.penable) begin
                    state_d = ST_ACCESS;
                    idx_d   = new_idx;
                    wr_d    = apb.pwrite;
                    err_d   = new_err;
                    wdata_d = apb.pwdata;
                    cnt_d   = WAIT_LD;
                    if (WAIT_LD == '0) begin
                        pready_d  = 1'b1;
                        pslverr_d = new_err;
                        prdata_d  = (!apb.pwrite && !new_err)
                                  ? mem_q[new_idx] : '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (!apb.psel) begin
                    state_d   = ST_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (apb.penable) begin
                    if (pready_q) begin
                        we        = wr_q && !err_q;
                        state_d   = ST_IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            pready_d  = 1'b1;
                            pslverr_d = err_q;
                            prdata_d  = (!wr_q && !err_q)
                                      ? mem_q[idx_q] : '0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
endmodule
